main_mem_arbiter: RTL and testbench

Three-way arbiter that shares the single main-memory port between the instruction cache, the data cache and a DMA/debug line-transfer master. It issues one line transaction at a time, rotates priority round-robin, forwards read data and ack to the owning requester, and drains killed transactions without delivering their responses. It sits between the cache tops and `main_mem` (or the DRAM bridge).

---
 rtl/main_mem_arbiter_if.sv | 49 ++++
 rtl/main_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_main_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_arbiter_if.sv
// Bundle of the three requester ports and the main-memory port around main_mem_arbiter.
// slave is the arbiter's view; master is the caches/DMA/memory environment.
interface main_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic              ic_req_i, ic_kill_i, ic_ack_o;
    logic [ADDR_W-1:0] ic_addr_i;
    logic [DATA_W-1:0] ic_rdata_o;

    logic              dc_req_i, dc_wen_i, dc_kill_i, dc_ack_o;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [DATA_W-1:0] dc_wdata_i, dc_rdata_o;

    logic              dma_req_i, dma_wen_i, dma_ack_o;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [DATA_W-1:0] dma_wdata_i, dma_rdata_o;

    logic              mem_req_o, mem_wen_o, mem_ack_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;

    logic [1:0]        grant_o;
    logic              busy_o;

    modport slave (
        input  ic_req_i, ic_kill_i, ic_addr_i,
        output ic_rdata_o, ic_ack_o,
        input  dc_req_i, dc_wen_i, dc_kill_i, dc_addr_i, dc_wdata_i,
        output dc_rdata_o, dc_ack_o,
        input  dma_req_i, dma_wen_i, dma_addr_i, dma_wdata_i,
        output dma_rdata_o, dma_ack_o,
        output mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i,
        output grant_o, busy_o
    );

    modport master (
        output ic_req_i, ic_kill_i, ic_addr_i,
        input  ic_rdata_o, ic_ack_o,
        output dc_req_i, dc_wen_i, dc_kill_i, dc_addr_i, dc_wdata_i,
        input  dc_rdata_o, dc_ack_o,
        output dma_req_i, dma_wen_i, dma_addr_i, dma_wdata_i,
        input  dma_rdata_o, dma_ack_o,
        input  mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter (dcache -> icache -> DMA) for the single main-memory line port.
// Optional MEM_ARB_TIMEOUT_EN: abandon a killed transaction after TIMEOUT_CYCLES drain cycles.
module main_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 239
) (
    input logic               clk,
    input logic               rst,
    main_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    localparam logic [1:0] NONE = 2'd0, IC = 2'd1, DC = 2'd2, DMA = 2'd3;

    state_t            state, state_nxt;
    logic [1:0]        grant, ptr, win;
    logic [3:0]        elig;
    logic              mem_req, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              owner_kill, fwd_ack;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0]        drain_cnt;
    logic              timeout;
`endif

    function automatic logic [1:0] succ(input logic [1:0] g);
        case (g)
            DC:      return IC;
            IC:      return DMA;
            default: return DC;
        endcase
    endfunction

    // A requester raising kill in IDLE simply sits out this round.
    always_comb begin
        elig = {bus.dma_req_i, bus.dc_req_i & ~bus.dc_kill_i, bus.ic_req_i & ~bus.ic_kill_i, 1'b0};
        win  = NONE;
        if (elig[ptr])                  win = ptr;
        else if (elig[succ(ptr)])       win = succ(ptr);
        else if (elig[succ(succ(ptr))]) win = succ(succ(ptr));
    end

    assign owner_kill = (grant == IC && bus.ic_kill_i) || (grant == DC && bus.dc_kill_i);
    assign fwd_ack    = (state == BUSY) && bus.mem_ack_i && !owner_kill;

`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout = (drain_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (win != NONE) state_nxt = BUSY;
            BUSY: begin
                if (owner_kill)         state_nxt = bus.mem_ack_i ? IDLE : DRAIN;
                else if (bus.mem_ack_i) state_nxt = IDLE;
            end
            DRAIN: begin
                if (bus.mem_ack_i) state_nxt = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timeout)  state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= NONE;
            ptr       <= DC;
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE && win != NONE) begin
            grant   <= win;
            ptr     <= succ(win);
            mem_req <= 1'b1;
            case (win)
                IC: begin
                    mem_addr  <= bus.ic_addr_i;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                end
                DC: begin
                    mem_addr  <= bus.dc_addr_i;
                    mem_wen   <= bus.dc_wen_i;
                    mem_wdata <= bus.dc_wdata_i;
                end
                default: begin
                    mem_addr  <= bus.dma_addr_i;
                    mem_wen   <= bus.dma_wen_i;
                    mem_wdata <= bus.dma_wdata_i;
                end
            endcase
        end else if (state != IDLE && state_nxt == IDLE) begin
            grant   <= NONE;
            mem_req <= 1'b0;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)                                    drain_cnt <= '0;
        else if (state == BUSY && state_nxt == DRAIN) drain_cnt <= '0;
        else if (state == DRAIN && !bus.mem_ack_i)  drain_cnt <= drain_cnt + 8'd1;
    end
`endif

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_wen_o   = mem_wen;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.grant_o     = grant;
    assign bus.busy_o      = (state != IDLE);

    assign bus.ic_ack_o    = fwd_ack && grant == IC;
    assign bus.dc_ack_o    = fwd_ack && grant == DC;
    assign bus.dma_ack_o   = fwd_ack && grant == DMA;
    assign bus.ic_rdata_o  = (fwd_ack && grant == IC)  ? bus.mem_rdata_i : '0;
    assign bus.dc_rdata_o  = (fwd_ack && grant == DC)  ? bus.mem_rdata_i : '0;
    assign bus.dma_rdata_o = (fwd_ack && grant == DMA) ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a cycle-level reference model checked every cycle.
// Define MEM_ARB_TIMEOUT_EN for both bench and RTL to exercise the drain timeout.
module tb_main_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int TMO = 239;

    localparam logic [DW-1:0] RD1 = 128'hDEADBEEF_00000000_11111111_CAFEBEEF;
    localparam logic [DW-1:0] WD2 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    localparam logic [DW-1:0] RD2 = 128'h55AA55AA_00000000_00000000_AA55AA55;
    localparam logic [DW-1:0] WD3 = 128'h0000D11A_0000D11A_0000D11A_0000D11A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    main_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    main_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // reference model: phase 0 idle, 1 transfer, 2 discarding a killed transfer
    int            m_phase = 0, m_owner = 0, m_rr = 0, m_cnt = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_wen = 1'b0;
    int            order[3] = '{2, 1, 3};

    logic          s_req, s_wen, s_busy, s_ic_ack, s_dc_ack, s_dma_ack;
    logic [1:0]    s_grant;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_ic_rdata, s_dc_rdata, s_dma_rdata;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic killed(input int r);
        return (r == 1 && bus.ic_kill_i) || (r == 2 && bus.dc_kill_i);
    endfunction

    function automatic logic eligible(input int r);
        case (r)
            1:       return bus.ic_req_i && !bus.ic_kill_i;
            2:       return bus.dc_req_i && !bus.dc_kill_i;
            default: return bus.dma_req_i;
        endcase
    endfunction

    task automatic model_step();
        logic ack_e;
        s_req = bus.mem_req_o;   s_wen = bus.mem_wen_o;     s_busy = bus.busy_o;
        s_addr = bus.mem_addr_o; s_wdata = bus.mem_wdata_o; s_grant = bus.grant_o;
        s_ic_ack = bus.ic_ack_o; s_dc_ack = bus.dc_ack_o;   s_dma_ack = bus.dma_ack_o;
        s_ic_rdata = bus.ic_rdata_o; s_dc_rdata = bus.dc_rdata_o; s_dma_rdata = bus.dma_rdata_o;

        ack_e = (m_phase == 1) && bus.mem_ack_i && !killed(m_owner);
        chk("m_mem_req", s_req, m_phase != 0);
        chk("m_grant", s_grant, m_owner);
        chk("m_busy", s_busy, m_phase != 0);
        chk("m_ic_ack", s_ic_ack, ack_e && m_owner == 1);
        chk("m_dc_ack", s_dc_ack, ack_e && m_owner == 2);
        chk("m_dma_ack", s_dma_ack, ack_e && m_owner == 3);
        chk("m_ic_rdata", s_ic_rdata, (ack_e && m_owner == 1) ? bus.mem_rdata_i : '0);
        chk("m_dc_rdata", s_dc_rdata, (ack_e && m_owner == 2) ? bus.mem_rdata_i : '0);
        chk("m_dma_rdata", s_dma_rdata, (ack_e && m_owner == 3) ? bus.mem_rdata_i : '0);
        if (m_phase != 0) begin
            chk("m_mem_addr", s_addr, m_addr);
            chk("m_mem_wen", s_wen, m_wen);
            chk("m_mem_wdata", s_wdata, m_wdata);
        end

        if (rst) begin
            m_phase = 0; m_owner = 0; m_rr = 0;
        end else if (m_phase == 0) begin
            for (int k = 0; k < 3; k++) begin
                int r;
                r = order[(m_rr + k) % 3];
                if (eligible(r)) begin
                    m_phase = 1; m_owner = r; m_rr = (m_rr + k + 1) % 3;
                    case (r)
                        1: begin m_addr = bus.ic_addr_i; m_wen = 1'b0; m_wdata = '0; end
                        2: begin m_addr = bus.dc_addr_i; m_wen = bus.dc_wen_i; m_wdata = bus.dc_wdata_i; end
                        default: begin m_addr = bus.dma_addr_i; m_wen = bus.dma_wen_i; m_wdata = bus.dma_wdata_i; end
                    endcase
                    break;
                end
            end
        end else if (m_phase == 1) begin
            if (killed(m_owner)) begin
                if (bus.mem_ack_i) begin m_phase = 0; m_owner = 0; end
                else begin m_phase = 2; m_cnt = 0; end
            end else if (bus.mem_ack_i) begin
                m_phase = 0; m_owner = 0;
            end
        end else begin
            if (bus.mem_ack_i) begin
                m_phase = 0; m_owner = 0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
                m_cnt++;
                if (m_cnt == TMO) begin m_phase = 0; m_owner = 0; end
            end
`endif
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.ic_req_i = 0;  bus.ic_kill_i = 0; bus.ic_addr_i = '0;
        bus.dc_req_i = 0;  bus.dc_wen_i = 0;  bus.dc_kill_i = 0; bus.dc_addr_i = '0; bus.dc_wdata_i = '0;
        bus.dma_req_i = 0; bus.dma_wen_i = 0; bus.dma_addr_i = '0; bus.dma_wdata_i = '0;
        bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
    endtask

    initial begin
        int rises[$];
        int gr[$];
        logic prev;
        int n;

        clr_in();
        rst = 1;
        cyc(); cyc();
        chk("rst_grant", s_grant, 0);
        chk("rst_mem_req", s_req, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_mem_addr", s_addr, 0);
        rst = 0;

        // icache read, ack three cycles after mem_req rises
        bus.ic_req_i = 1; bus.ic_addr_i = 32'h8000_0040;
        cyc();
        bus.ic_req_i = 0; bus.ic_addr_i = 32'h0BAD_0000;
        cyc();
        chk("ic_rd_req", s_req, 1);
        chk("ic_rd_grant", s_grant, 1);
        chk("ic_rd_addr", s_addr, 32'h8000_0040);
        chk("ic_rd_wen", s_wen, 0);
        cyc(); cyc();
        bus.mem_ack_i = 1; bus.mem_rdata_i = RD1;
        cyc();
        chk("ic_rd_ack", s_ic_ack, 1);
        chk("ic_rd_rdata", s_ic_rdata, RD1);
        chk("ic_rd_dc_ack", s_dc_ack, 0);
        bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
        cyc();
        chk("ic_rd_grant_clr", s_grant, 0);
        chk("ic_rd_ack_clr", s_ic_ack, 0);

        // dcache write
        bus.dc_req_i = 1; bus.dc_wen_i = 1; bus.dc_addr_i = 32'h8000_1000; bus.dc_wdata_i = WD2;
        cyc();
        bus.dc_req_i = 0; bus.dc_wen_i = 0; bus.dc_wdata_i = '0;
        cyc();
        chk("dc_wr_grant", s_grant, 2);
        chk("dc_wr_wen", s_wen, 1);
        chk("dc_wr_wdata", s_wdata, WD2);
        chk("dc_wr_addr", s_addr, 32'h8000_1000);
        bus.mem_ack_i = 1; bus.mem_rdata_i = RD2;
        cyc();
        chk("dc_wr_ack", s_dc_ack, 1);
        chk("dc_wr_ic_ack", s_ic_ack, 0);
        bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
        cyc();

        // all three requesting continuously from reset; memory acks one cycle after mem_req
        rst = 1; cyc(); rst = 0;
        bus.ic_req_i = 1;  bus.ic_addr_i = 32'h8000_2000;
        bus.dc_req_i = 1;  bus.dc_addr_i = 32'h8000_3000;
        bus.dma_req_i = 1; bus.dma_addr_i = 32'h8000_4000; bus.dma_wen_i = 1; bus.dma_wdata_i = WD3;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (s_req && !prev) begin
                rises.push_back(i);
                gr.push_back(int'(s_grant));
            end
            prev = s_req;
            bus.mem_ack_i = s_req && !bus.mem_ack_i;
        end
        chk("rr_count", gr.size(), 5);
        if (gr.size() >= 4) begin
            chk("rr_g0", gr[0], 2);
            chk("rr_g1", gr[1], 1);
            chk("rr_g2", gr[2], 3);
            chk("rr_g3", gr[3], 2);
            chk("rr_bubble", rises[1] - rises[0], 3);
            chk("rr_bubble2", rises[3] - rises[2], 3);
        end
        clr_in();
        rst = 1; cyc(); rst = 0;
        cyc();
        chk("rst_mid_busy", s_busy, 0);

        // icache killed one cycle after grant, dcache pending
        bus.ic_req_i = 1; bus.ic_addr_i = 32'h8000_5000;
        cyc();
        bus.ic_kill_i = 1; bus.dc_req_i = 1; bus.dc_addr_i = 32'h8000_6000;
        cyc();
        bus.ic_kill_i = 0; bus.ic_req_i = 0;
        cyc();
        chk("kill_drain_busy", s_busy, 1);
        chk("kill_drain_req", s_req, 1);
        cyc(); cyc(); cyc();
        bus.mem_ack_i = 1; bus.mem_rdata_i = RD1;
        cyc();
        chk("kill_no_ic_ack", s_ic_ack, 0);
        chk("kill_no_dc_ack", s_dc_ack, 0);
        bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
        cyc();
        chk("kill_idle_req", s_req, 0);
        chk("kill_idle_busy", s_busy, 0);
        cyc();
        chk("kill_next_grant", s_grant, 2);
        chk("kill_next_addr", s_addr, 32'h8000_6000);
        bus.dc_req_i = 0; bus.mem_ack_i = 1; bus.mem_rdata_i = RD2;
        cyc();
        chk("kill_next_dc_ack", s_dc_ack, 1);
        bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
        cyc();

        // kill and memory ack in the same cycle
        bus.ic_req_i = 1; bus.ic_addr_i = 32'h8000_7000;
        cyc();
        bus.ic_req_i = 0; bus.ic_kill_i = 1; bus.mem_ack_i = 1; bus.mem_rdata_i = RD1;
        cyc();
        chk("kill_ack_no_ack", s_ic_ack, 0);
        chk("kill_ack_rdata", s_ic_rdata, 0);
        bus.ic_kill_i = 0; bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
        cyc();
        chk("kill_ack_idle", s_busy, 0);
        chk("kill_ack_req", s_req, 0);

        // dcache killed, memory never answers
        bus.dc_req_i = 1; bus.dc_addr_i = 32'h8000_8000;
        cyc();
        bus.dc_req_i = 0; bus.dc_kill_i = 1;
        cyc();
        bus.dc_kill_i = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (s_busy) n++;
            else break;
        end
        chk("tmo_drain_cycles", n, TMO);
        chk("tmo_req_low", s_req, 0);
`else
        n = 0;
        repeat (1000) begin
            cyc();
            if (s_busy) n++;
        end
        chk("no_tmo_drain_cycles", n, 1000);
        chk("no_tmo_still_busy", s_busy, 1);
        chk("no_tmo_req", s_req, 1);
`endif
        rst = 1; cyc(); rst = 0;
        bus.mem_ack_i = 1; bus.mem_rdata_i = RD2;
        cyc();
        chk("late_ack_dc", s_dc_ack, 0);
        chk("late_ack_busy", s_busy, 0);
        bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
